// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - pops FIFO entries and packs them little-endian into a valid/ready output word
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_COUNT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_read_data,
  output logic                             fifo_read_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [PACK_COUNT-1:0]            out_keep
);

  localparam int OUT_WIDTH = DATA_WIDTH * PACK_COUNT;
  localparam int IW        = $clog2(PACK_COUNT);
  localparam logic [IW-1:0] LAST_LANE = IW'(PACK_COUNT - 1);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [IW-1:0]         r_lane_idx;
  logic [OUT_WIDTH-1:0]  r_out_data;
  logic [PACK_COUNT-1:0] r_out_keep;
  logic                  w_pop;
  logic                  w_handshake;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      S_FILL: begin
        w_pop = !fifo_empty;
        // A pop always wins over a simultaneous flush
        if (w_pop) begin
          w_next_state = S_CAPTURE;
        end else if (flush && (r_lane_idx != '0)) begin
          w_next_state = S_HOLD;
        end
      end
      S_CAPTURE: begin
        w_next_state = (r_lane_idx == LAST_LANE) ? S_HOLD : S_FILL;
      end
      S_HOLD: begin
        w_handshake = out_ready;
        if (out_ready) begin
          w_next_state = S_FILL;
        end
      end
      default: w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FILL;
      r_lane_idx <= '0;
      r_out_data <= '0;
      r_out_keep <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_CAPTURE) begin
        r_out_data[r_lane_idx*DATA_WIDTH +: DATA_WIDTH] <= fifo_read_data;
        r_out_keep[r_lane_idx]                          <= 1'b1;
        if (r_lane_idx != LAST_LANE) begin
          r_lane_idx <= r_lane_idx + IW'(1);
        end
      end else if (w_handshake) begin
        r_out_data <= '0;
        r_out_keep <= '0;
        r_lane_idx <= '0;
      end
    end
  end

  // Read enable is gated by reset so no pop can be issued while reset is held
  assign fifo_read_en = w_pop && rst;
  assign out_valid    = (r_state == S_HOLD);
  assign out_data     = r_out_data;
  assign out_keep     = r_out_keep;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - randomized scoreboard bench for fifo_word_packer
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PC = 4;
  localparam int OW = DW * PC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_read_data = '0;
  logic          fifo_read_en;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [PC-1:0] out_keep;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_keep       (out_keep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  logic [OW-1:0] exp_d[$];
  logic [PC-1:0] exp_k[$];

  logic pop_now    = 1'b0;
  logic force_empty = 1'b0;
  logic stall_mode = 1'b0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: entries land in lanes in arrival order; every PC entries make a word
  function automatic void emit_pend();
    logic [OW-1:0] d;
    logic [PC-1:0] k;
    d = '0;
    k = '0;
    for (int i = 0; i < pend.size(); i++) begin
      d[i*DW +: DW] = pend[i];
      k[i]          = 1'b1;
    end
    exp_d.push_back(d);
    exp_k.push_back(k);
    pend.delete();
  endfunction

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
    pend.push_back(v);
    if (pend.size() == PC) emit_pend();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      pop_now = fifo_read_en;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_now && rst && fq.size() != 0) fifo_read_data = fq.pop_front();
      if (stall_mode) force_empty = ($urandom_range(0, 3) == 0);
      else            force_empty = 1'b0;
      fifo_empty = force_empty || (fq.size() == 0);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  logic          held = 1'b0;
  logic [OW-1:0] last_d;
  logic [PC-1:0] last_k;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0;
      end else if (out_valid) begin
        chk("hold_read_en", 64'(fifo_read_en), 64'd0);
        if (held) begin
          chk("hold_data_stable", 64'(out_data), 64'(last_d));
          chk("hold_keep_stable", 64'(out_keep), 64'(last_k));
        end
        if (out_ready) begin
          if (exp_d.size() == 0) begin
            chk("unexpected_word", 64'(out_data), 64'hDEAD_BEEF_0000_0000);
          end else begin
            chk("word_data", 64'(out_data), 64'(exp_d.pop_front()));
            chk("word_keep", 64'(out_keep), 64'(exp_k.pop_front()));
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          last_d = out_data;
          last_k = out_keep;
        end
      end else if (held) begin
        chk("valid_dropped", 64'(out_valid), 64'd1);
        held = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_d.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk(name, 64'(exp_d.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_read_en(input string name);
    int n;
    n = 0;
    while (!fifo_read_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk(name, 64'(fifo_read_en), 64'd1);
  endtask

  initial begin
    int k;
    int seen;

    // 1: reset with a non-empty FIFO
    @(negedge clk);
    fq.push_back(8'h5A);
    repeat (2) @(negedge clk);
    chk("rst_read_en", 64'(fifo_read_en), 64'd0);
    chk("rst_valid",   64'(out_valid),    64'd0);
    chk("rst_data",    64'(out_data),     64'd0);
    chk("rst_keep",    64'(out_keep),     64'd0);
    fq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 2: full word, latency and single-cycle handshake
    ready_mode = 1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_read_en("t2_first_pop_timeout");
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t2_valid_latency", 64'(k), 64'd8);
    chk("t2_word", 64'(out_data), 64'h44332211);
    @(negedge clk);
    chk("t2_one_cycle_handshake", 64'(out_valid), 64'd0);
    wait_drain("t2_drain_timeout");

    // 3: backpressure with FIFO refilled during HOLD
    ready_mode = 0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    push(8'h99); push(8'hAA); push(8'hBB); push(8'hCC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_data", 64'(out_data), 64'h88776655);
      chk("t3_hold_read_en", 64'(fifo_read_en), 64'd0);
    end
    ready_mode = 1;
    k = 0;
    while (!(out_valid && out_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("t3_resume_pop", 64'(fifo_read_en), 64'd1);
    wait_drain("t3_drain_timeout");

    // 4: flush of a partial word, flush at lane 0, flush during CAPTURE
    push(8'hAA); push(8'hBB);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    emit_pend();
    @(negedge clk);
    flush = 1'b0;
    wait_drain("t4_partial_timeout");
    seen = 0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t4_flush_lane0_ignored", 64'(seen), 64'd0);
    push(8'hCC);
    wait_read_en("t4_capture_pop_timeout");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    push(8'hDD); push(8'hEE); push(8'hFF);
    wait_drain("t4_capture_drain_timeout");

    // 5: reset mid-word discards the partial lanes
    push(8'h0A); push(8'h0B); push(8'h0C);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    pend.delete();
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t5_no_output_after_reset", 64'(seen), 64'd0);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_drain("t5_drain_timeout");

    // 6: streaming with random backpressure, then random data with random empty stalls
    ready_mode = 2;
    for (int i = 0; i < 8; i++) push(8'(i));
    wait_drain("t6_stream_timeout");
    stall_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_drain("t6_random_timeout");
    stall_mode = 1'b0;
    ready_mode = 1;
    repeat (4) @(negedge clk);

    chk("final_queue_empty", 64'(exp_d.size()), 64'd0);
    chk("final_fifo_empty", 64'(fq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
